// File: rtl/uart_tx_fifo.sv
// Console transmitter: byte FIFO feeding an 8N1 serialiser.
// Raises stallreq_o while the FIFO is full; overflow_o is sticky.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_en_i,
  input  logic [31:0]                   uart_data_i,
  output logic                          stallreq_o,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CW     = ADDR_W + 1;
  localparam int CPB    = CLK_FREQ / BAUD_RATE;
  localparam int BW     = $clog2(CPB);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              ovf_q, ovf_d;
  logic              full, push, pop, bit_end;
  logic              data_unused;

  assign data_unused = ^uart_data_i[31:8];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = uart_en_i & ~full;
  assign bit_end = (baud_q == BW'(CPB - 1));

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | (uart_en_i & full);
  end

  // Frame sequencer: start, 8 data bits LSB first, stop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the coming cycle, registered so txd never glitches
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_d];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= uart_data_i[7:0];
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stallreq_o = full;
  assign busy_o     = (state_q != IDLE) | (count_q != '0);
  assign count_o    = count_q;
  assign txd_o      = txd_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: 4 clocks per bit, 4-entry FIFO.
// A line receiver decodes frames and checks them against a byte queue.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_en_i = 1'b0;
  logic [31:0] uart_data_i = '0;
  logic        stallreq_o, txd_o, busy_o, overflow_o;
  logic [2:0]  count_o;

  uart_tx_fifo #(
    .CLK_FREQ  (400),
    .BAUD_RATE (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_en_i  (uart_en_i),
    .uart_data_i(uart_data_i),
    .stallreq_o (stallreq_o),
    .txd_o      (txd_o),
    .busy_o     (busy_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q [$];
  int  frames_done = 0;
  int  mon_starts  = 0;
  int  last_start  = 0;
  int  prev_start  = 0;
  logic mon_busy   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line receiver: one sample per cycle, whole frame must be exact
  initial begin
    logic s [40];
    logic [7:0] rx;
    logic [7:0] e;
    logic ab, okf;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd_o === 1'b0) begin
        mon_busy   = 1'b1;
        mon_starts++;
        prev_start = last_start;
        last_start = cyc;
        ab   = 1'b0;
        s[0] = txd_o;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) ab = 1'b1;
          s[i] = txd_o;
        end
        okf = (s[0] == 1'b0) && (s[36] == 1'b1);
        for (int g = 0; g < 10; g++)
          for (int k = 1; k < 4; k++)
            if (s[4*g+k] !== s[4*g]) okf = 1'b0;
        for (int i = 0; i < 8; i++) rx[i] = s[4+4*i];
        if (!ab) begin
          frames_done++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame: got %0h expected none", rx);
          end else begin
            e = exp_q.pop_front();
            if (!okf || rx !== e) begin
              n_err++;
              $display("FAIL frame: got %0h (fmt ok %0d) expected %0h",
                       rx, okf, e);
            end
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic put(input logic [7:0] b);
    uart_en_i   = 1'b1;
    uart_data_i = {24'hDEAD_BE, b};
    @(negedge clk);
    uart_en_i   = 1'b0;
    uart_data_i = '0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_o || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk({name, "_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c, f0, s0;
    // Reset state and idle line
    @(negedge clk);
    @(negedge clk);
    chk("rst_txd", txd_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", count_o, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_txd", txd_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_stall", stallreq_o, 0);
    chk("idle_count", count_o, 0);
    chk("idle_ovf", overflow_o, 0);
    chk("idle_frames", mon_starts, 0);

    // Single byte: latency and frame length
    c = cyc;
    exp_q.push_back(8'hA5);
    put(8'hA5);
    chk("t2_txd_n1", txd_o, 1);
    chk("t2_cnt_n1", count_o, 1);
    @(negedge clk);
    chk("t2_txd_n2", txd_o, 0);
    chk("t2_cnt_n2", count_o, 0);
    chk("t2_start", last_start, c + 2);
    wait_until(c + 41);
    chk("t2_busy_end", busy_o, 1);
    chk("t2_stop", txd_o, 1);
    @(negedge clk);
    chk("t2_busy_off", busy_o, 0);
    wait_idle("t2");

    // Back-to-back frames without gap
    c = cyc;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    put(8'h00);
    put(8'hFF);
    chk("t3_cnt_a", count_o, 1);
    wait_until(c + 41);
    chk("t3_cnt_b", count_o, 1);
    @(negedge clk);
    chk("t3_cnt_c", count_o, 0);
    chk("t3_txd_c", txd_o, 0);
    wait_idle("t3");
    chk("t3_first", prev_start, c + 2);
    chk("t3_gap", last_start - prev_start, 40);

    // Overfill: sixth byte dropped
    f0 = frames_done;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    put(8'h11);
    put(8'h22);
    put(8'h33);
    put(8'h44);
    put(8'h55);
    chk("t4_stall", stallreq_o, 1);
    chk("t4_cnt_full", count_o, 4);
    chk("t4_ovf_pre", overflow_o, 0);
    put(8'h66);
    chk("t4_ovf", overflow_o, 1);
    chk("t4_cnt_hold", count_o, 4);
    wait_idle("t4");
    chk("t4_frames", frames_done - f0, 5);
    chk("t4_ovf_sticky", overflow_o, 1);

    // Push while full on the same cycle as a pop
    do_reset();
    chk("t5_ovf_clr", overflow_o, 0);
    c = cyc;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h84);
    exp_q.push_back(8'h85);
    put(8'h81);
    put(8'h82);
    put(8'h83);
    put(8'h84);
    put(8'h85);
    wait_until(c + 41);
    chk("t5_cnt_pre", count_o, 4);
    chk("t5_ovf_pre", overflow_o, 0);
    put(8'h3C);
    chk("t5_cnt_post", count_o, 3);
    chk("t5_ovf_post", overflow_o, 1);
    chk("t5_stall", stallreq_o, 0);
    wait_idle("t5");

    // Reset in the middle of data bit 3
    do_reset();
    c = cyc;
    put(8'hC3);
    put(8'h0F);
    put(8'hF0);
    wait_until(c + 19);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_txd", txd_o, 1);
    chk("t6_cnt", count_o, 0);
    chk("t6_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    f0 = frames_done;
    s0 = mon_starts;
    repeat (60) @(negedge clk);
    chk("t6_no_frames", mon_starts - s0, 0);
    chk("t6_done", frames_done - f0, 0);
    chk("t6_idle_txd", txd_o, 1);
    exp_q.push_back(8'h5A);
    put(8'h5A);
    wait_idle("t6");
    chk("t6_after", frames_done - f0, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
